// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREGS = 8;

  // One pending bit per architectural register.
  function automatic int unsigned pend_w(input int unsigned nregs);
    return nregs;
  endfunction

endpackage

// File: rtl/regfile_word.sv
// Single register word with async active-low clear and load enable.
//   clk   : rising-edge clock
//   rst_b : async active-low reset, clears q
//   ld    : load d into q on the next rising edge
//   d     : load value
//   q     : stored value
module regfile_word #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through bypass and a one-bit-per-register
// pending scoreboard for operand hazard detection.
//   clk, rst_b           : clock, async active-low reset
//   wr_en/addr/data      : write-back port (clears pending)
//   iss_en/addr          : issue port (sets pending on destination)
//   flush                : clears every pending bit
//   rda_*/rdb_*          : two combinational read ports with busy flags
//   stall                : either read operand is busy
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  input  logic [AW-1:0]    rda_addr,
  input  logic [AW-1:0]    rdb_addr,
  output logic [WIDTH-1:0] rda_data,
  output logic [WIDTH-1:0] rdb_data,
  output logic             rda_busy,
  output logic             rdb_busy,
  output logic             stall
);

  localparam int unsigned PW = pend_w(NREGS);

  logic [WIDTH-1:0] words [NREGS];
  logic [NREGS-1:0] wr_sel;
  logic [NREGS-1:0] iss_sel;
  logic [PW-1:0]    pending;
  logic [PW-1:0]    pending_nxt;

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_busy [2];

  // Address decode; indices at or above NREGS match no word and are dropped.
  always_comb begin
    wr_sel  = '0;
    iss_sel = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wr_en && (wr_addr == AW'(i))) wr_sel[i] = 1'b1;
      if (iss_en && (iss_addr == AW'(i))) iss_sel[i] = 1'b1;
    end
  end

  // Storage words.
  for (genvar g = 0; g < NREGS; g++) begin : g_word
    regfile_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_b (rst_b),
      .ld    (wr_sel[g]),
      .d     (wr_data),
      .q     (words[g])
    );
  end

  // Scoreboard next state: flush dominates; issue set applied after
  // write-back clear so a same-cycle re-issue keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (flush) begin
      pending_nxt = '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wr_sel[i])  pending_nxt[i] = 1'b0;
        if (iss_sel[i]) pending_nxt[i] = 1'b1;
      end
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign rd_addr[0] = rda_addr;
  assign rd_addr[1] = rdb_addr;

  // Read ports: a same-cycle write-back supplies the data and resolves busy.
  always_comb begin
    rd_data = '{default: '0};
    rd_busy = '{default: 1'b0};
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (rd_addr[p] == AW'(i)) begin
          if (wr_sel[i]) begin
            rd_data[p] = wr_data;
            rd_busy[p] = 1'b0;
          end else begin
            rd_data[p] = words[i];
            rd_busy[p] = pending[i];
          end
        end
      end
    end
  end

  assign rda_data = rd_data[0];
  assign rdb_data = rd_data[1];
  assign rda_busy = rd_busy[0];
  assign rdb_busy = rd_busy[1];
  assign stall    = rd_busy[0] | rd_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: an 8-entry and a 6-entry instance share stimulus;
// an array model predicts every read output at each falling edge.
module tb_regfile_sb;

  logic        clk;
  logic        rst_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic        flush;
  logic [2:0]  rda_addr;
  logic [2:0]  rdb_addr;

  logic [15:0] ra_d [2];
  logic [15:0] rb_d [2];
  logic        ra_b [2];
  logic        rb_b [2];
  logic        st   [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  // Model state: index 0 is the 8-entry build, index 1 the 6-entry build.
  int unsigned nr [2] = '{8, 6};
  logic [15:0] m_reg  [2][8];
  bit          m_pend [2][8];

  regfile_sb u_dut8 (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .rda_addr(rda_addr), .rdb_addr(rdb_addr),
    .rda_data(ra_d[0]), .rdb_data(rb_d[0]), .rda_busy(ra_b[0]), .rdb_busy(rb_b[0]),
    .stall(st[0])
  );

  regfile_sb #(.NREGS(6)) u_dut6 (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .rda_addr(rda_addr), .rdb_addr(rdb_addr),
    .rda_data(ra_d[1]), .rdb_data(rb_d[1]), .rda_busy(ra_b[1]), .rdb_busy(rb_b[1]),
    .stall(st[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: what the register file must contain after each edge.
  always @(posedge clk or negedge rst_b) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_b) begin
        for (int i = 0; i < 8; i++) begin
          m_reg[k][i]  = 16'h0000;
          m_pend[k][i] = 1'b0;
        end
      end else begin
        if (flush) begin
          for (int i = 0; i < 8; i++) m_pend[k][i] = 1'b0;
        end else begin
          if (wr_en && int'(wr_addr) < int'(nr[k])) m_pend[k][wr_addr] = 1'b0;
          if (iss_en && int'(iss_addr) < int'(nr[k])) m_pend[k][iss_addr] = 1'b1;
        end
        if (wr_en && int'(wr_addr) < int'(nr[k])) m_reg[k][wr_addr] = wr_data;
      end
    end
  end

  function automatic logic [15:0] exp_data(input int k, input logic [2:0] a);
    if (int'(a) >= int'(nr[k])) return 16'h0000;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [2:0] a);
    if (int'(a) >= int'(nr[k])) return 1'b0;
    return m_pend[k][a] && !(wr_en && wr_addr == a);
  endfunction

  // Every falling edge: all outputs of both builds against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d rda_data", k), 32'(ra_d[k]), 32'(exp_data(k, rda_addr)));
        chk($sformatf("m%0d rdb_data", k), 32'(rb_d[k]), 32'(exp_data(k, rdb_addr)));
        chk($sformatf("m%0d rda_busy", k), 32'(ra_b[k]), 32'(exp_busy(k, rda_addr)));
        chk($sformatf("m%0d rdb_busy", k), 32'(rb_b[k]), 32'(exp_busy(k, rdb_addr)));
        chk($sformatf("m%0d stall", k), 32'(st[k]),
            32'(exp_busy(k, rda_addr) | exp_busy(k, rdb_addr)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; idle();
    wr_addr = '0; wr_data = '0; iss_addr = '0; rda_addr = '0; rdb_addr = '0;
    tick(); tick();
    chk_on = 1'b1;
    rst_b = 1'b1;
    tick();

    // Post-reset sweep on both ports.
    for (int i = 0; i < 8; i++) begin
      rda_addr = 3'(i); rdb_addr = 3'(7 - i);
      @(negedge clk);
      chk("rst rda_data", 32'(ra_d[0]), 32'h0);
      chk("rst rdb_data", 32'(rb_d[0]), 32'h0);
      chk("rst stall", 32'(st[0]), 32'h0);
      tick();
    end

    // Write-through bypass then stored value.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rda_addr = 3'd3;
    @(negedge clk);
    chk("bypass rda_data", 32'(ra_d[0]), 32'hBEEF);
    tick(); idle();
    @(negedge clk);
    chk("stored rda_data", 32'(ra_d[0]), 32'hBEEF);
    tick();

    // Issue, hazard, same-cycle resolve.
    iss_en = 1'b1; iss_addr = 3'd5;
    tick(); idle(); rdb_addr = 3'd5; rda_addr = 3'd5;
    @(negedge clk);
    chk("hazard rdb_busy", 32'(rb_b[0]), 32'h1);
    chk("hazard stall", 32'(st[0]), 32'h1);
    tick();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    @(negedge clk);
    chk("resolve rdb_busy", 32'(rb_b[0]), 32'h0);
    chk("resolve rdb_data", 32'(rb_d[0]), 32'h1234);
    tick(); idle();
    @(negedge clk);
    chk("cleared rdb_busy", 32'(rb_b[0]), 32'h0);
    tick();

    // Issue and write-back same address same cycle: new producer wins.
    iss_en = 1'b1; iss_addr = 3'd2; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hA5A5;
    tick(); idle(); rda_addr = 3'd2;
    @(negedge clk);
    chk("iss+wr rda_data", 32'(ra_d[0]), 32'hA5A5);
    chk("iss+wr rda_busy", 32'(ra_b[0]), 32'h1);
    tick();
    // Double issue then a single write-back clears.
    iss_en = 1'b1; iss_addr = 3'd2;
    tick(); idle();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0202;
    tick(); idle();
    @(negedge clk);
    chk("single wb rda_busy", 32'(ra_b[0]), 32'h0);
    tick();

    // Flush wins over a same-cycle issue.
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      iss_en = 1'b1; iss_addr = (i == 0) ? 3'd1 : (i == 1) ? 3'd4 : 3'd6;
      tick();
    end
    idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 3'd7;
    tick(); idle(); rda_addr = 3'd1; rdb_addr = 3'd4;
    @(negedge clk);
    chk("flush rda_busy(1)", 32'(ra_b[0]), 32'h0);
    chk("flush rdb_busy(4)", 32'(rb_b[0]), 32'h0);
    chk("flush rdb_data(4)", 32'(rb_d[0]), 32'h4444);
    tick(); rda_addr = 3'd6; rdb_addr = 3'd7;
    @(negedge clk);
    chk("flush stall(6,7)", 32'(st[0]), 32'h0);
    tick();

    // Mid-cycle reset pulse drops pending and data immediately.
    iss_en = 1'b1; iss_addr = 3'd4;
    tick(); idle(); rda_addr = 3'd4; rdb_addr = 3'd4;
    @(negedge clk);
    chk("pre-rst rda_busy", 32'(ra_b[0]), 32'h1);
    chk("pre-rst rda_data", 32'(ra_d[0]), 32'h4444);
    #1 rst_b = 1'b0;
    #1;
    chk("async rda_busy", 32'(ra_b[0]), 32'h0);
    chk("async rda_data", 32'(ra_d[0]), 32'h0);
    chk("async stall", 32'(st[0]), 32'h0);
    #1 rst_b = 1'b1;
    tick();

    // Bypass still visible while held in reset; nothing is stored.
    rst_b = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h7777; rda_addr = 3'd3; rdb_addr = 3'd3;
    @(negedge clk);
    chk("in-rst bypass", 32'(rb_d[0]), 32'h7777);
    chk("in-rst busy", 32'(ra_b[0]), 32'h0);
    tick(); idle();
    rst_b = 1'b1;
    @(negedge clk);
    chk("post-rst reg3", 32'(ra_d[0]), 32'h0);
    tick();

    // Out-of-range index on the 6-entry build.
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hDEAD; iss_en = 1'b1; iss_addr = 3'd7;
    rda_addr = 3'd7; rdb_addr = 3'd7;
    @(negedge clk);
    chk("n6 rda_data(7)", 32'(ra_d[1]), 32'h0);
    chk("n8 rda_data(7)", 32'(ra_d[0]), 32'hDEAD);
    tick(); idle();
    @(negedge clk);
    chk("n6 rda_busy(7)", 32'(ra_b[1]), 32'h0);
    chk("n6 stored(7)", 32'(rb_d[1]), 32'h0);
    chk("n8 rda_busy(7)", 32'(ra_b[0]), 32'h1);
    tick();

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 24; i++) begin
      wr_en    = (i % 2) == 1;
      wr_addr  = 3'(i * 3);
      wr_data  = 16'(16'h1000 + i * 16'h0111);
      iss_en   = (i % 3) == 0;
      iss_addr = 3'(i * 5);
      flush    = (i == 11);
      rda_addr = 3'(i);
      rdb_addr = 3'(i * 7);
      tick();
    end
    idle();
    tick();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per register.
REQ-002 SHALL have parameter NREGS, default 8, number of registers (2..32).
REQ-003 SHALL have parameter AW, default $clog2(NREGS), address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_b  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en  input  1  write-back strobe.
REQ-007 SHALL have port wr_addr  input  AW  write-back register index.
REQ-008 SHALL have port wr_data  input  WIDTH  write-back value.
REQ-009 SHALL have port iss_en  input  1  issue strobe; marks destination pending.
REQ-010 SHALL have port iss_addr  input  AW  issued destination index.
REQ-011 SHALL have port flush  input  1  synchronous clear of all pending marks.
REQ-012 SHALL have ports rda_addr and rdb_addr  input  AW each  read-port indices.
REQ-013 SHALL have ports rda_data and rdb_data  output  WIDTH each  read values.
REQ-014 SHALL have ports rda_busy and rdb_busy  output  1 each  operand not yet available.
REQ-015 SHALL have port stall  output  1  OR of rda_busy and rdb_busy.

Function
REQ-016 Storage SHALL be NREGS x WIDTH flops; reg[wr_addr] <= wr_data on edge when wr_en=1 and wr_addr<NREGS.
REQ-017 Reads SHALL be combinational, zero latency: rdX_data = wr_data when wr_en=1 and wr_addr==rdX_addr, else reg[rdX_addr] (write-through bypass, both ports independently).
REQ-018 Read address >= NREGS SHALL return all zeros and busy=0; write or issue to such address SHALL be ignored.
REQ-019 Scoreboard SHALL hold one pending bit per register.
REQ-020 Pending bit update per edge, priority high to low: flush -> all bits 0 (iss_en same cycle also ignored); iss_en -> bit[iss_addr]=1; wr_en -> bit[wr_addr]=0.
REQ-021 iss_en and wr_en to the same address in the same cycle SHALL leave the bit set (new producer wins); data write still occurs.
REQ-022 Issue to an already pending register SHALL keep it pending (no counting); one write-back clears it.
REQ-023 rdX_busy SHALL be pending[rdX_addr] AND NOT (wr_en AND wr_addr==rdX_addr); a same-cycle write-back resolves the hazard.
REQ-024 Write-back to a non-pending register SHALL be accepted; pending bit stays 0.
REQ-025 Both read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-026 rst_b=0 SHALL asynchronously force all registers to 0 and all pending bits to 0, independent of clk.
REQ-027 During reset, read outputs SHALL reflect bypass from wr_data if wr_en=1 to a matching address, else 0; busy and stall SHALL be 0.
REQ-028 Reset deassertion mid-operation SHALL discard all in-flight pending marks; first edge after release behaves per REQ-016..REQ-024.

Structure
REQ-029 Package regfile_pkg SHALL hold default WIDTH, default NREGS and the pending-vector type width helper.
REQ-030 One sub-module regfile_word SHALL implement a single WIDTH-bit register with async active-low reset and load enable; instantiated NREGS times via generate.
REQ-031 Bypass muxes and scoreboard SHALL live in the top level; no latches, no combinational loops.

Verification
REQ-032 Reset, then read all addresses on both ports -> data 0x0000, busy 0, stall 0.
REQ-033 wr_en=1 addr 3 data 0xBEEF with rda_addr=3 same cycle -> rda_data=0xBEEF before edge; after edge wr_en=0 -> still 0xBEEF.
REQ-034 iss_en addr 5; next cycle rdb_addr=5 -> rdb_busy=1, stall=1; wr_en addr 5 data 0x1234 -> same cycle rdb_busy=0, rdb_data=0x1234; next cycle busy 0.
REQ-035 iss_en and wr_en both addr 2 same cycle -> after edge reg2=written data, pending[2]=1, rda_busy(2)=1.
REQ-036 Issue regs 1,4,6, assert flush with iss_en addr 7 -> after edge all busy 0 including 7; data unchanged.
REQ-037 Pending on reg 4, pulse rst_b low between edges -> busy drops immediately, reg4 reads 0x0000; NREGS=6 build: read addr 7 -> 0, busy 0; write addr 7 ignored.
